// File: rtl/udp_perf_pkt_checker.sv
// rtl/udp_perf_pkt_checker.sv - UDP RX stream pattern checker with throughput counters
module udp_perf_pkt_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64
) (
  input  logic                  udp_clk,
  input  logic                  udp_reset,
  input  logic                  recv_enable,
  input  logic [31:0]           pkt_size,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  is_recv_first_pkt,
  output logic [31:0]           perf_cycle_count,
  output logic                  perf_cycle_count_full,
  output logic [31:0]           perf_beat_count,
  output logic [31:0]           total_beat_count,
  output logic [31:0]           recv_pkt_count,
  output logic [31:0]           err_pkt_count
);

  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    RUNNING  = 2'd2
  } state_t;

  state_t            state;
  logic              in_pkt;
  logic [7:0]        seq;
  logic [1:0]        beat_idx;
  logic              err_sticky;
  logic [31:0]       byte_total;
  logic [31:0]       cyc_cnt;

  logic              accept;
  logic              boundary;
  logic [1:0]        cur_idx;
  logic [31:0]       total_base;
  logic              err_base;
  logic [CNT_W-1:0]  keep_ones;
  logic [KEEP_WIDTH-1:0] keep_plus;
  logic              keep_all;
  logic              keep_contig;
  logic              data_err;
  logic              beat_err;
  logic [32:0]       byte_sum;
  logic [31:0]       total_next;
  logic              err_next;
  logic              pkt_bad;

  assign perf_cycle_count = cyc_cnt;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign boundary = accept & s_axis_tlast;

  // A beat with no packet in progress starts fresh per-packet accumulators
  assign cur_idx    = in_pkt ? beat_idx : 2'd0;
  assign total_base = in_pkt ? byte_total : 32'd0;
  assign err_base   = in_pkt ? err_sticky : 1'b0;

  // Count kept bytes in the current beat
  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_ones = keep_ones + CNT_W'(s_axis_tkeep[i]);
    end
  end

  // tkeep is a legal last-beat mask when it is nonzero and of the form 0..01..1
  assign keep_plus   = s_axis_tkeep + {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
  assign keep_all    = &s_axis_tkeep;
  assign keep_contig = ((s_axis_tkeep & keep_plus) == '0) && (s_axis_tkeep != '0);

  // Compare every kept lane against the rolling byte pattern for this beat
  always_comb begin
    data_err = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      logic [7:0] exp_byte;
      exp_byte = seq + {cur_idx, 6'd0} + 8'(i);
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != exp_byte)) begin
        data_err = 1'b1;
      end
    end
  end

  assign beat_err = s_axis_tuser
                  | (!s_axis_tlast && !keep_all)
                  | (s_axis_tlast && !keep_contig)
                  | data_err;

  // Saturating byte total; a saturated total can only match pkt_size=0xFFFFFFFF
  assign byte_sum   = {1'b0, total_base} + {{(33-CNT_W){1'b0}}, keep_ones};
  assign total_next = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
  assign err_next   = err_base | beat_err;
  assign pkt_bad    = err_next | (total_next != pkt_size) | (pkt_size == 32'd0);

  // Stream bookkeeping, measurement FSM and all counters
  always_ff @(posedge udp_clk or posedge udp_reset) begin
    if (udp_reset) begin
      state                 <= DISABLED;
      in_pkt                <= 1'b0;
      seq                   <= 8'd0;
      beat_idx              <= 2'd0;
      err_sticky            <= 1'b0;
      byte_total            <= 32'd0;
      cyc_cnt               <= 32'd0;
      s_axis_tready         <= 1'b0;
      is_recv_first_pkt     <= 1'b0;
      perf_cycle_count_full <= 1'b0;
      perf_beat_count       <= 32'd0;
      total_beat_count      <= 32'd0;
      recv_pkt_count        <= 32'd0;
      err_pkt_count         <= 32'd0;
    end else begin
      s_axis_tready <= 1'b1;

      if (accept) begin
        total_beat_count <= total_beat_count + 32'd1;
        in_pkt           <= !s_axis_tlast;
        beat_idx         <= cur_idx + 2'd1;
        byte_total       <= total_next;
        err_sticky       <= err_next;
      end

      case (state)
        DISABLED: begin
          // Never arm while a dropped packet is still streaming through
          if (recv_enable && !in_pkt && !(accept && !s_axis_tlast)) begin
            state                 <= ARMED;
            cyc_cnt               <= 32'd0;
            perf_cycle_count_full <= 1'b0;
            perf_beat_count       <= 32'd0;
            recv_pkt_count        <= 32'd0;
            err_pkt_count         <= 32'd0;
            seq                   <= 8'd0;
            is_recv_first_pkt     <= 1'b0;
          end
        end

        ARMED: begin
          if (accept) begin
            is_recv_first_pkt <= 1'b1;
            cyc_cnt           <= 32'd1;
            perf_beat_count   <= 32'd1;
            if (s_axis_tlast) begin
              seq <= seq + 8'd1;
              if (pkt_bad) err_pkt_count  <= err_pkt_count + 32'd1;
              else         recv_pkt_count <= recv_pkt_count + 32'd1;
            end
            state <= (s_axis_tlast && !recv_enable) ? DISABLED : RUNNING;
          end else if (!recv_enable) begin
            state <= DISABLED;
          end
        end

        RUNNING: begin
          if (cyc_cnt != 32'hFFFF_FFFF) cyc_cnt <= cyc_cnt + 32'd1;
          perf_cycle_count_full <= perf_cycle_count_full | (cyc_cnt >= 32'hFFFF_FFFE);
          if (accept && !perf_cycle_count_full) begin
            perf_beat_count <= perf_beat_count + 32'd1;
          end
          if (boundary) begin
            seq <= seq + 8'd1;
            if (pkt_bad) err_pkt_count  <= err_pkt_count + 32'd1;
            else         recv_pkt_count <= recv_pkt_count + 32'd1;
          end
          // Disable only between packets so an in-flight packet finishes here
          if (!recv_enable && (boundary || (!in_pkt && !accept))) begin
            state <= DISABLED;
          end
        end

        default: state <= DISABLED;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_perf_pkt_checker.sv
// tb/tb_udp_perf_pkt_checker.sv - randomized self-checking bench for udp_perf_pkt_checker
module tb_udp_perf_pkt_checker;

  localparam int DW = 512;
  localparam int KW = 64;

  logic          udp_clk = 1'b0;
  logic          udp_reset;
  logic          recv_enable;
  logic [31:0]   pkt_size;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          is_recv_first_pkt;
  logic [31:0]   perf_cycle_count;
  logic          perf_cycle_count_full;
  logic [31:0]   perf_beat_count;
  logic [31:0]   total_beat_count;
  logic [31:0]   recv_pkt_count;
  logic [31:0]   err_pkt_count;

  udp_perf_pkt_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .udp_clk              (udp_clk),
    .udp_reset            (udp_reset),
    .recv_enable          (recv_enable),
    .pkt_size             (pkt_size),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .is_recv_first_pkt    (is_recv_first_pkt),
    .perf_cycle_count     (perf_cycle_count),
    .perf_cycle_count_full(perf_cycle_count_full),
    .perf_beat_count      (perf_beat_count),
    .total_beat_count     (total_beat_count),
    .recv_pkt_count       (recv_pkt_count),
    .err_pkt_count        (err_pkt_count)
  );

  always #5 udp_clk = ~udp_clk;

  int unsigned tb_cycle = 0;
  always @(posedge udp_clk) tb_cycle <= tb_cycle + 1;

  // reference model: packet-level view of the measurement window
  bit          m_active;
  bit          m_running;
  bit          m_full;
  int unsigned m_recv, m_err, m_pbeats, m_total, m_first_cycle;
  logic [7:0]  m_seq;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge udp_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic model_clear_window();
    m_running = 0; m_full = 0;
    m_recv = 0; m_err = 0; m_pbeats = 0; m_seq = 8'd0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, ":recv"},  recv_pkt_count,   m_recv);
    chk({tag, ":err"},   err_pkt_count,    m_err);
    chk({tag, ":pbeat"}, perf_beat_count,  m_pbeats);
    chk({tag, ":total"}, total_beat_count, m_total);
    chk({tag, ":first"}, {31'd0, is_recv_first_pkt},     {31'd0, m_running});
    chk({tag, ":full"},  {31'd0, perf_cycle_count_full}, {31'd0, m_full});
    if (m_full)
      chk({tag, ":cyc_sat"}, perf_cycle_count, 32'hFFFF_FFFF);
    else if (!m_running)
      chk({tag, ":cyc_idle"}, perf_cycle_count, 32'd0);
  endtask

  task automatic set_enable(input bit v);
    recv_enable = v;
    idle(2);
    if (v && !m_active) begin
      m_active = 1;
      model_clear_window();
    end else if (!v) begin
      m_active = 0;
    end
  endtask

  // fault: 0 none, 1 corrupt byte, 2 tuser, 3 short non-last tkeep, 4 holey last tkeep
  task automatic send_packet(input string tag, input int len, input int fault_in,
                             input bit drop_en);
    int nb, last_n, fault, cidx, tub;
    logic [KW-1:0] keep [4];
    logic [DW-1:0] data [4];
    bit good;
    nb     = (len + 63) / 64;
    last_n = len - 64 * (nb - 1);
    fault  = fault_in;
    if (fault == 3 && !(nb > 1 && last_n < 64)) fault = 0;
    if (fault == 4 && !(last_n >= 2 && last_n < 64)) fault = 0;
    for (int b = 0; b < nb; b++) begin
      keep[b] = '0;
      for (int i = 0; i < 64; i++) begin
        data[b][8*i +: 8] = 8'(m_seq + 8'(64 * b + i));
        if (b < nb - 1 || i < last_n) keep[b][i] = 1'b1;
      end
    end
    cidx = $urandom_range(len - 1, 0);
    tub  = $urandom_range(nb - 1, 0);
    if (fault == 1) data[cidx / 64][8*(cidx % 64) +: 8] ^= 8'h5A;
    if (fault == 3) begin keep[0][63] = 1'b0; keep[nb-1][last_n] = 1'b1; end
    if (fault == 4) begin keep[nb-1][0] = 1'b0; keep[nb-1][last_n] = 1'b1; end
    for (int b = 0; b < nb; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = data[b];
      s_axis_tkeep  = keep[b];
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = (fault == 2 && b == tub);
      tick();
      if (b == 0 && m_active && !m_running) begin
        m_running = 1;
        m_first_cycle = tb_cycle;
        chk({tag, ":first_rise"}, {31'd0, is_recv_first_pkt}, 32'd1);
        chk({tag, ":cyc_start"}, perf_cycle_count, 32'd1);
      end
      if (b == 0 && drop_en) recv_enable = 1'b0;
      if (b != nb - 1 && $urandom_range(2, 0) == 0) idle($urandom_range(2, 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    good = (fault == 0) && (len == int'(pkt_size)) && (pkt_size != 32'd0);
    m_total += nb;
    if (m_active) begin
      if (!m_full) m_pbeats += nb;
      if (good) m_recv++; else m_err++;
      m_seq++;
      if (m_running && !m_full)
        chk({tag, ":cyc"}, perf_cycle_count, tb_cycle - m_first_cycle + 1);
      if (drop_en) m_active = 0;
    end
    check_counters(tag);
    idle($urandom_range(2, 0));
  endtask

  initial begin
    udp_reset = 1'b1; recv_enable = 1'b0; pkt_size = 32'd100;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    m_active = 0; m_total = 0;
    model_clear_window();
    repeat (3) tick();
    chk("reset:tready", {31'd0, s_axis_tready}, 32'd0);
    check_counters("reset");
    udp_reset = 1'b0;
    tick();
    chk("post_reset:tready", {31'd0, s_axis_tready}, 32'd1);

    // packets while disabled: only total_beat_count moves
    send_packet("dis0", 100, 0, 0);
    send_packet("dis1", 100, 0, 0);
    set_enable(1);
    check_counters("armed");

    // three correct 2-beat packets
    for (int p = 0; p < 3; p++) send_packet("good3", 100, 0, 0);
    chk("good3:recv_final", recv_pkt_count, 32'd3);

    // corrupted byte 70 then a correct seq=1 packet
    set_enable(0); set_enable(1);
    send_packet("corrupt", 100, 1, 0);
    send_packet("after_corrupt", 100, 0, 0);

    // length mismatch, tuser, short non-last keep, holey last keep
    set_enable(0); set_enable(1);
    pkt_size = 32'd128;
    send_packet("len_err", 100, 0, 0);
    pkt_size = 32'd100;
    send_packet("tuser", 100, 2, 0);
    send_packet("nonlast_keep", 100, 3, 0);
    send_packet("holey_keep", 100, 4, 0);
    send_packet("good_after", 100, 0, 0);
    pkt_size = 32'd0;
    send_packet("size0", 1, 0, 0);

    // randomized traffic with random sizes and faults
    for (int ph = 0; ph < 4; ph++) begin
      set_enable(0); set_enable(1);
      case ($urandom_range(3, 0))
        0: pkt_size = 32'd1;
        1: pkt_size = 32'd64;
        2: pkt_size = 32'd0;
        default: pkt_size = $urandom_range(255, 1);
      endcase
      for (int p = 0; p < 8; p++) begin
        int len, f;
        len = ($urandom_range(3, 0) == 0 || pkt_size == 0) ? $urandom_range(255, 1)
                                                           : int'(pkt_size);
        f = ($urandom_range(2, 0) == 0) ? $urandom_range(4, 1) : 0;
        send_packet("rand", len, f, 0);
      end
    end

    // enable dropped mid-packet: packet still counted, then window frozen
    set_enable(0); set_enable(1);
    pkt_size = 32'd150;
    send_packet("midpkt_drop", 150, 0, 1);
    idle(3);
    send_packet("after_drop", 150, 0, 0);

    // cycle counter saturation via backdoor
    set_enable(1);
    send_packet("pre_sat", 150, 0, 0);
    force dut.cyc_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_cnt;
    tick();
    m_full = 1;
    chk("sat:cyc", perf_cycle_count, 32'hFFFF_FFFF);
    chk("sat:full", {31'd0, perf_cycle_count_full}, 32'd1);
    tick();
    chk("sat:cyc_hold", perf_cycle_count, 32'hFFFF_FFFF);
    send_packet("sat_frozen", 150, 0, 0);

    // reset in the middle of a 3-beat packet, then a 1-byte packet
    pkt_size = 32'd1;
    s_axis_tvalid = 1'b1; s_axis_tkeep = '1; s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    tick();
    #3 udp_reset = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    m_active = 0; m_total = 0;
    model_clear_window();
    chk("midreset:tready", {31'd0, s_axis_tready}, 32'd0);
    check_counters("midreset");
    tick();
    udp_reset = 1'b0;
    set_enable(1);
    send_packet("post_reset_1B", 1, 0, 0);
    chk("post_reset_1B:recv_final", recv_pkt_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/udp_perf_pkt_checker.md
UDP_PERF_PKT_CHECKER -- requirements
Module: udp_perf_pkt_checker

Interface
REQ-001 SHALL have exactly one clock and one reset: one clock; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- DATA_WIDTH, default 512, AXIS data width in bits.
- KEEP_WIDTH, default 64, DATA_WIDTH/8.
REQ-003 Ports SHALL be, one per line:
- udp_clk  in  1  sole clock.
- udp_reset  in  1  asynchronous active-high reset.
- recv_enable  in  1  measurement enable, level.
- pkt_size  in  32  expected packet length in bytes.
- s_axis_tvalid  in  1  UDP RX stream valid.
- s_axis_tready  out  1  UDP RX stream ready.
- s_axis_tdata  in  DATA_WIDTH  payload; byte 0 is bits 7:0.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tuser  in  1  upstream error flag.
- is_recv_first_pkt  out  1  first beat seen since arming.
- perf_cycle_count  out  32  cycles since first beat.
- perf_cycle_count_full  out  1  cycle counter saturated.
- perf_beat_count  out  32  beats inside the measurement window.
- total_beat_count  out  32  all accepted beats, free-running.
- recv_pkt_count  out  32  good packets.
- err_pkt_count  out  32  bad packets.

Function
REQ-004 s_axis_tready SHALL be 0 while udp_reset is asserted, and 1 on every cycle otherwise; the block never back-pressures.
REQ-005 A beat is accepted when s_axis_tvalid && s_axis_tready; a packet boundary is an accepted beat with tlast=1.
REQ-006 FSM states SHALL be DISABLED, ARMED and RUNNING.
REQ-007 Transitions: DISABLED->ARMED when recv_enable=1 and no packet is in progress.
REQ-008 ARMED->RUNNING on the first accepted beat; that beat is checked and counted.
REQ-009 ARMED or RUNNING->DISABLED when recv_enable=0, sampled only at a packet boundary or when no packet is in progress.
REQ-010 Entering ARMED SHALL clear, on the same edge: perf_cycle_count, perf_cycle_count_full, perf_beat_count, recv_pkt_count, err_pkt_count, the sequence counter and is_recv_first_pkt.
REQ-011 Packets that begin while in DISABLED SHALL be accepted and dropped, not checked and not counted except in total_beat_count.
REQ-012 Expected byte value: byte k of packet n = (seq + k) mod 256, where seq is an 8-bit counter of completed packets (good or bad) since arming, wrapping 255->0.
REQ-013 Per-beat expected byte at lane i SHALL be computed as seq + 64*(beat_idx mod 4) + i, mod 256; beat_idx is a 2-bit wrapping count of beats within the packet.
REQ-014 A packet SHALL be bad if any of the following holds:
- any accepted beat has tuser=1;
- a non-last beat has tkeep != all-ones;
- a last beat has non-contiguous tkeep (not of form 0..01..1) or tkeep=0;
- any kept byte mismatches the expected value;
- the byte total (sum of tkeep popcounts) != pkt_size.
REQ-015 Error state SHALL be sticky within the packet; pkt_size=0 makes every packet bad.
REQ-016 The byte total SHALL be a 32-bit accumulator saturating at 0xFFFFFFFF; saturation forces a length error unless pkt_size=0xFFFFFFFF.
REQ-017 On each boundary in RUNNING, exactly one of recv_pkt_count / err_pkt_count SHALL increment, visible 1 cycle after the tlast beat; seq increments on the same edge.
REQ-018 Packet counters SHALL wrap at 2^32.
REQ-019 is_recv_first_pkt SHALL rise 1 cycle after the ARMED->RUNNING beat and hold until the next arming or reset.
REQ-020 In RUNNING, perf_cycle_count SHALL increment every cycle, starting at 1 on the cycle after the first beat; it saturates at 0xFFFFFFFF, where perf_cycle_count_full goes to 1.
REQ-021 perf_beat_count SHALL count accepted beats in RUNNING, including the first beat, and freeze once perf_cycle_count_full=1.
REQ-022 total_beat_count SHALL count every accepted beat in any state and wrap at 2^32.
REQ-023 In DISABLED, all counters except total_beat_count SHALL hold their values for readout.
REQ-024 recv_enable toggling mid-packet SHALL take effect only at the next boundary; the in-flight packet completes in its current state.

Reset
REQ-025 udp_reset SHALL asynchronously force:
- state DISABLED, no packet in progress;
- all counters and seq to 0;
- perf_cycle_count_full=0, is_recv_first_pkt=0, s_axis_tready=0.
REQ-026 Reset mid-packet SHALL discard that packet; the first beat after release is treated as a new packet start.

Verification
REQ-027 pkt_size=100, enable, send 3 correct 2-beat packets (64+36 bytes, seq 0,1,2) -> recv_pkt_count=3, err_pkt_count=0, perf_beat_count=6, total_beat_count=6.
REQ-028 pkt_size=100, send a packet with byte 70 corrupted, then a correct packet with seq=1 -> err_pkt_count=1, recv_pkt_count=1.
REQ-029 Send a 100-byte packet with pkt_size=128, and one with tuser=1 on beat 0 -> err_pkt_count=2; non-last tkeep=0x7FFF...F -> error.
REQ-030 Send 2 packets with enable=0, then raise enable -> total_beat_count counts them, all other counters 0; is_recv_first_pkt=0 until the next beat.
REQ-031 Force perf_cycle_count to 0xFFFFFFFE via a long run or backdoor -> after 1 cycle reads 0xFFFFFFFF, full=1, perf_beat_count frozen.
REQ-032 Assert udp_reset during beat 2 of a 3-beat packet, then send 1 correct 1-byte packet (seq 0, pkt_size=1) -> recv_pkt_count=1, err_pkt_count=0.
